id_ex_stage: RTL and testbench

- ID/EX pipeline register of the pipelined LEGv8 core. Captures decoded control and operands at the end of decode.
- Presents ex_aluop and ex_funct to the ALU control decoder in execute, and the remaining fields to the ALU and later stages.
- Contains load-use hazard detection and inserts a bubble when a hazard is found.
- Supports pipeline flush on a taken branch and a global hold.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/id_ex_stage_if.sv | 57 +++++
 rtl/id_ex_stage_hazard_unit.sv | 28 ++
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared LEGv8 core types: control bundle, ALU op classes, zero register.
// Pure declarations; no timing or flow control.
// Imported by the ID/EX stage, its hazard unit and the stage interface.
package cpu_pkg;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
        logic branch;
    } ctrl_t;

    localparam logic [1:0] ALUOP_MEM  = 2'b00;
    localparam logic [1:0] ALUOP_CBZ  = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_CBNZ = 2'b11;

    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: id_* fields in, ex_* fields and stall out.
// Latency is set by the stage using it; this interface only carries wires.
// Backpressure: stall flows upstream, hold and flush flow in from control.
interface id_ex_stage_if #(
    parameter int N  = 64,
    parameter int RW = 5
);
    import cpu_pkg::*;

    logic          hold;
    logic          flush;

    logic          id_valid;
    logic [1:0]    id_aluop;
    logic [10:0]   id_funct;
    ctrl_t         id_ctrl;
    logic [N-1:0]  id_rd1;
    logic [N-1:0]  id_rd2;
    logic [N-1:0]  id_imm;
    logic [N-1:0]  id_pc;
    logic [RW-1:0] id_rn;
    logic [RW-1:0] id_rm;
    logic [RW-1:0] id_rd;

    logic          ex_valid;
    logic [1:0]    ex_aluop;
    logic [10:0]   ex_funct;
    ctrl_t         ex_ctrl;
    logic [N-1:0]  ex_rd1;
    logic [N-1:0]  ex_rd2;
    logic [N-1:0]  ex_imm;
    logic [N-1:0]  ex_pc;
    logic [RW-1:0] ex_rn;
    logic [RW-1:0] ex_rm;
    logic [RW-1:0] ex_rd;

    logic          stall;

    modport master (
        output hold, flush,
        output id_valid, id_aluop, id_funct, id_ctrl, id_rd1, id_rd2, id_imm, id_pc,
        output id_rn, id_rm, id_rd,
        input  ex_valid, ex_aluop, ex_funct, ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc,
        input  ex_rn, ex_rm, ex_rd,
        input  stall
    );

    modport slave (
        input  hold, flush,
        input  id_valid, id_aluop, id_funct, id_ctrl, id_rd1, id_rd2, id_imm, id_pc,
        input  id_rn, id_rm, id_rd,
        output ex_valid, ex_aluop, ex_funct, ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc,
        output ex_rn, ex_rm, ex_rd,
        output stall
    );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use detector: a load in EX whose destination is read by the decode slot.
// Latency: purely combinational.
// Backpressure: its stall output is the upstream freeze request; flush masks it.
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic          flush,
    input  logic          ex_valid,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_rd,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rn,
    input  logic [RW-1:0] id_rm,
    output logic          stall
);

    logic reg_match;
    logic load_in_ex;

    assign reg_match  = (ex_rd == id_rn) || (ex_rd == id_rm);
    // A load into XZR produces no value, so nothing can depend on it.
    assign load_in_ex = ex_valid && ex_memread && (ex_rd != RW'(XZR));

    assign stall = !flush && load_in_ex && id_valid && reg_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; IDEX_PERF_CNT_EN adds bubble/flush counters.
// Latency: 1 cycle id_* -> ex_*, no combinational id -> ex path.
// Backpressure: hold freezes the register; stall (combinational) freezes PC/IF-ID for one cycle.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int N  = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]   bubble_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    typedef struct packed {
        logic          valid;
        logic [1:0]    aluop;
        logic [10:0]   funct;
        ctrl_t         ctrl;
        logic [N-1:0]  rd1;
        logic [N-1:0]  rd2;
        logic [N-1:0]  imm;
        logic [N-1:0]  pc;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [RW-1:0] rd;
    } stage_t;

    stage_t ex_q;
    stage_t id_load;
    logic   stall;

    hazard_unit #(.RW(RW)) u_hazard (
        .flush      (bus.flush),
        .ex_valid   (ex_q.valid),
        .ex_memread (ex_q.ctrl.memread),
        .ex_rd      (ex_q.rd),
        .id_valid   (bus.id_valid),
        .id_rn      (bus.id_rn),
        .id_rm      (bus.id_rm),
        .stall      (stall)
    );

    always_comb begin
        id_load.valid = bus.id_valid;
        id_load.aluop = bus.id_aluop;
        id_load.funct = bus.id_funct;
        id_load.ctrl  = bus.id_ctrl;
        id_load.rd1   = bus.id_rd1;
        id_load.rd2   = bus.id_rd2;
        id_load.imm   = bus.id_imm;
        id_load.pc    = bus.id_pc;
        id_load.rn    = bus.id_rn;
        id_load.rm    = bus.id_rm;
        id_load.rd    = bus.id_rd;
        // An empty slot still carries its fields but must have no side effects downstream.
        if (!bus.id_valid) begin
            id_load.ctrl  = '0;
            id_load.aluop = ALUOP_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (!bus.hold) begin
            ex_q <= stall ? stage_t'('0) : id_load;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (bus.flush) begin
            flush_cnt  <= flush_cnt + 32'd1;
        end else if (!bus.hold && stall) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

    assign bus.ex_valid = ex_q.valid;
    assign bus.ex_aluop = ex_q.aluop;
    assign bus.ex_funct = ex_q.funct;
    assign bus.ex_ctrl  = ex_q.ctrl;
    assign bus.ex_rd1   = ex_q.rd1;
    assign bus.ex_rd2   = ex_q.rd2;
    assign bus.ex_imm   = ex_q.imm;
    assign bus.ex_pc    = ex_q.pc;
    assign bus.ex_rn    = ex_q.rn;
    assign bus.ex_rm    = ex_q.rm;
    assign bus.ex_rd    = ex_q.rd;
    assign bus.stall    = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of normal loads plus hand-built hazard/flush/hold/reset sequences.
// Expected ex_* records are queued when stimulus is driven and compared one cycle later.
module tb_id_ex_stage;
    import cpu_pkg::*;

    localparam int N  = 64;
    localparam int RW = 5;

    typedef struct packed {
        logic          v;
        logic [1:0]    aluop;
        logic [10:0]   funct;
        logic [5:0]    ctrl;
        logic [N-1:0]  rd1;
        logic [N-1:0]  rd2;
        logic [N-1:0]  imm;
        logic [N-1:0]  pc;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [RW-1:0] rd;
    } fields_t;

    typedef struct {
        string   name;
        fields_t in;
        fields_t exp;
        logic    exp_stall;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if #(.N(N), .RW(RW)) bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] flush_cnt;
`endif

    id_ex_stage #(.N(N), .RW(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    int      total = 0;
    int      bad   = 0;
    fields_t sb[$];
    vec_t    tbl[5];

    localparam logic [10:0] F_ADD  = 11'b10001011000;
    localparam logic [10:0] F_SUB  = 11'b11001011000;
    localparam logic [10:0] F_ORR  = 11'b10101010000;
    localparam logic [10:0] F_LDUR = 11'b11111000010;
    localparam logic [10:0] F_STUR = 11'b11111000000;
    localparam logic [10:0] F_CBZ  = 11'b10110100000;
    localparam logic [5:0]  C_R    = 6'b100000;
    localparam logic [5:0]  C_LD   = 6'b110110;
    localparam logic [5:0]  C_ST   = 6'b001010;
    localparam logic [5:0]  C_BR   = 6'b000001;

    function automatic fields_t mk(logic v, logic [1:0] aluop, logic [10:0] funct, logic [5:0] ctrl,
                                   logic [N-1:0] rd1, logic [N-1:0] rd2, logic [N-1:0] imm,
                                   logic [N-1:0] pc, logic [RW-1:0] rn, logic [RW-1:0] rm,
                                   logic [RW-1:0] rd);
        fields_t f;
        f.v = v; f.aluop = aluop; f.funct = funct; f.ctrl = ctrl;
        f.rd1 = rd1; f.rd2 = rd2; f.imm = imm; f.pc = pc;
        f.rn = rn; f.rm = rm; f.rd = rd;
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input fields_t f, input logic fl, input logic hd);
        bus.id_valid = f.v;
        bus.id_aluop = f.aluop;
        bus.id_funct = f.funct;
        bus.id_ctrl  = ctrl_t'(f.ctrl);
        bus.id_rd1   = f.rd1;
        bus.id_rd2   = f.rd2;
        bus.id_imm   = f.imm;
        bus.id_pc    = f.pc;
        bus.id_rn    = f.rn;
        bus.id_rm    = f.rm;
        bus.id_rd    = f.rd;
        bus.flush    = fl;
        bus.hold     = hd;
    endtask

    task automatic compare_ex(input string name, input fields_t e);
        check({name, ".valid"}, 64'(bus.ex_valid), 64'(e.v));
        check({name, ".aluop"}, 64'(bus.ex_aluop), 64'(e.aluop));
        check({name, ".funct"}, 64'(bus.ex_funct), 64'(e.funct));
        check({name, ".ctrl"},  64'(bus.ex_ctrl),  64'(e.ctrl));
        check({name, ".rd1"},   bus.ex_rd1, e.rd1);
        check({name, ".rd2"},   bus.ex_rd2, e.rd2);
        check({name, ".imm"},   bus.ex_imm, e.imm);
        check({name, ".pc"},    bus.ex_pc,  e.pc);
        check({name, ".rn"},    64'(bus.ex_rn), 64'(e.rn));
        check({name, ".rm"},    64'(bus.ex_rm), 64'(e.rm));
        check({name, ".rd"},    64'(bus.ex_rd), 64'(e.rd));
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input string name, input fields_t in, input logic fl, input logic hd,
                        input fields_t exp, input logic exp_stall);
        fields_t e;
        drive(in, fl, hd);
        sb.push_back(exp);
        #1;
        check({name, ".stall"}, 64'(bus.stall), 64'(exp_stall));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=0 expected=1", name);
        end else begin
            e = sb.pop_front();
            compare_ex(name, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fields_t bub, add3, ld4, sub5, sub5_nv, ld31, add7, ld6, add8, cbz, orr9, junk;
        bub     = '0;
        add3    = mk(1, ALUOP_R,   F_ADD,  C_R,  64'd5,      64'd7,      64'd0,    64'h100, 5'd1,  5'd2, 5'd3);
        ld4     = mk(1, ALUOP_MEM, F_LDUR, C_LD, 64'h2000,   64'd0,      64'd0,    64'h10c, 5'd1,  5'd0, 5'd4);
        sub5    = mk(1, ALUOP_R,   F_SUB,  C_R,  64'd99,     64'd7,      64'd0,    64'h200, 5'd4,  5'd2, 5'd5);
        sub5_nv = mk(0, ALUOP_R,   F_SUB,  C_R,  64'd99,     64'd7,      64'd0,    64'h204, 5'd4,  5'd2, 5'd5);
        ld31    = mk(1, ALUOP_MEM, F_LDUR, C_LD, 64'h3000,   64'd0,      64'd0,    64'h208, 5'd1,  5'd0, 5'd31);
        add7    = mk(1, ALUOP_R,   F_ADD,  C_R,  64'd0,      64'd7,      64'd0,    64'h20c, 5'd31, 5'd2, 5'd7);
        ld6     = mk(1, ALUOP_MEM, F_LDUR, C_LD, 64'h4000,   64'd0,      64'd16,   64'h214, 5'd4,  5'd0, 5'd6);
        add8    = mk(1, ALUOP_R,   F_ADD,  C_R,  64'd1,      64'd2,      64'd0,    64'h218, 5'd6,  5'd2, 5'd8);
        cbz     = mk(1, ALUOP_CBZ, F_CBZ,  C_BR, 64'd0,      64'h55,     64'h40,   64'h220, 5'd0,  5'd4, 5'd0);
        orr9    = mk(1, ALUOP_R,   F_ORR,  C_R,  64'hf0f0,   64'h0f0f,   64'd0,    64'h224, 5'd1,  5'd2, 5'd9);

        tbl[0] = '{"add",   add3, add3, 1'b0};
        tbl[1] = '{"inval",
                   mk(0, ALUOP_R, F_ADD, C_R, 64'd9, 64'd11, 64'd3, 64'h104, 5'd4, 5'd5, 5'd6),
                   mk(0, ALUOP_MEM, F_ADD, 6'b0, 64'd9, 64'd11, 64'd3, 64'h104, 5'd4, 5'd5, 5'd6),
                   1'b0};
        tbl[2] = '{"stur",
                   mk(1, ALUOP_MEM, F_STUR, C_ST, 64'h2000, 64'hdead, 64'd8, 64'h108, 5'd1, 5'd2, 5'd2),
                   mk(1, ALUOP_MEM, F_STUR, C_ST, 64'h2000, 64'hdead, 64'd8, 64'h108, 5'd1, 5'd2, 5'd2),
                   1'b0};
        tbl[3] = '{"ldur",  ld4, ld4, 1'b0};
        tbl[4] = '{"indep",
                   mk(1, ALUOP_R, F_ADD, C_R, 64'd1, 64'd2, 64'd0, 64'h110, 5'd1, 5'd2, 5'd6),
                   mk(1, ALUOP_R, F_ADD, C_R, 64'd1, 64'd2, 64'd0, 64'h110, 5'd1, 5'd2, 5'd6),
                   1'b0};

        reset = 1'b1;
        drive(bub, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        compare_ex("reset", bub);
        check("reset.stall", 64'(bus.stall), 64'd0);
        reset = 1'b0;

        foreach (tbl[i]) step(tbl[i].name, tbl[i].in, 1'b0, 1'b0, tbl[i].exp, tbl[i].exp_stall);

        // Load-use: one bubble, then the consumer proceeds.
        step("lu_ld",    ld4,  1'b0, 1'b0, ld4,  1'b0);
        step("lu_stall", sub5, 1'b0, 1'b0, bub,  1'b1);
        step("lu_sub",   sub5, 1'b0, 1'b0, sub5, 1'b0);

        step("nv_ld", ld4, 1'b0, 1'b0, ld4, 1'b0);
        step("nv_id", sub5_nv, 1'b0, 1'b0,
             mk(0, ALUOP_MEM, F_SUB, 6'b0, 64'd99, 64'd7, 64'd0, 64'h204, 5'd4, 5'd2, 5'd5), 1'b0);

        step("xzr_ld",  ld31, 1'b0, 1'b0, ld31, 1'b0);
        step("xzr_use", add7, 1'b0, 1'b0, add7, 1'b0);

        // Back-to-back dependent loads, then a consumer of the second load.
        step("b2b_ld4",   ld4,  1'b0, 1'b0, ld4,  1'b0);
        step("b2b_stall", ld6,  1'b0, 1'b0, bub,  1'b1);
        step("b2b_ld6",   ld6,  1'b0, 1'b0, ld6,  1'b0);
        step("b2b_st2",   add8, 1'b0, 1'b0, bub,  1'b1);
        step("b2b_add",   add8, 1'b0, 1'b0, add8, 1'b0);

        // Hold with a hazard pending: stall stays visible, no bubble until released.
        step("hh_ld",    ld4,  1'b0, 1'b0, ld4,  1'b0);
        step("hh_hold",  sub5, 1'b0, 1'b1, ld4,  1'b1);
        step("hh_stall", sub5, 1'b0, 1'b0, bub,  1'b1);
        step("hh_sub",   sub5, 1'b0, 1'b0, sub5, 1'b0);

        // Flush beats hold and masks the load-use match on Rt.
        step("fl_ld",  ld4, 1'b0, 1'b0, ld4, 1'b0);
        step("fl_cbz", cbz, 1'b1, 1'b1, bub, 1'b0);
`ifdef IDEX_PERF_CNT_EN
        check("bubble_cnt", 64'(bubble_cnt), 64'd4);
        check("flush_cnt",  64'(flush_cnt),  64'd1);
`endif

        step("hold_orr", orr9, 1'b0, 1'b0, orr9, 1'b0);
        for (int k = 0; k < 3; k++) begin
            junk = mk(1, 2'($urandom), 11'($urandom), 6'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom));
            step($sformatf("hold%0d", k), junk, 1'b0, 1'b1, orr9, 1'b0);
        end
`ifdef IDEX_PERF_CNT_EN
        check("hold_bubble_cnt", 64'(bubble_cnt), 64'd4);
`endif

        // Reset mid-stream with a valid instruction waiting in decode.
        drive(add3, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_ex("rst_mid", bub);
        check("rst_mid.stall", 64'(bus.stall), 64'd0);
`ifdef IDEX_PERF_CNT_EN
        check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        check("rst_flush_cnt",  64'(flush_cnt),  64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
